// File: rtl/game2048_pkg.sv
// Shared definitions for the 2048 game datapath: move directions, the button
// debouncer state encoding and the one-hot button decoder.
package game2048_pkg;

  localparam int DIR_W = 2;
  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_PRESSED = 2'd2
  } btn_state_e;

  typedef struct packed {
    logic ok;
    dir_t dir;
  } cand_t;

  // Buttons are packed {right,left,down,up}; anything other than exactly one
  // pressed button is reported as "no press".
  function automatic cand_t decode_btn(input logic [3:0] s);
    cand_t c;
    c.ok  = 1'b1;
    c.dir = DIR_UP;
    case (s)
      4'b0001: c.dir = DIR_UP;
      4'b0010: c.dir = DIR_DOWN;
      4'b0100: c.dir = DIR_LEFT;
      4'b1000: c.dir = DIR_RIGHT;
      default: c.ok  = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; each bit is treated
// independently, so only slowly changing levels belong on it.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments let both flops sample on the same edge, giving a true two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_dir_ctrl.sv
// Debounces the four direction buttons on the 100 ms strobe, auto-repeats held
// moves and offers them to the game FSM through a 1-entry valid/ready register.
module btn_dir_ctrl
  import game2048_pkg::*;
#(
  parameter int unsigned DEB_TICKS     = 2,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 5,
  parameter int unsigned REPEAT_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_100ms,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output logic move_valid,
  output dir_t move_dir,
  input  logic move_ready,
  output logic move_drop
);

  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int          DCNT_W = $clog2(DEB_TICKS + 1);
  localparam int          RCNT_W = $clog2(RMAX + 1);

  localparam logic [DCNT_W-1:0] DEB_MAX  = DCNT_W'(DEB_TICKS);
  localparam logic [RCNT_W-1:0] R_DELAY  = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] R_PERIOD = RCNT_W'(REPEAT_PERIOD);
  localparam logic [RCNT_W-1:0] R_MAX    = RCNT_W'(RMAX);

  logic [3:0] btn_raw;
  logic [3:0] btn_s;
  cand_t      cand;

  btn_state_e        state_q, state_d;
  dir_t              cand_q, cand_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d, dcnt_inc;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d, rcnt_inc, rcnt_tgt;
  logic              first_q, first_d;

  logic match;
  logic deb_done;
  logic rep_due;
  logic emit;

  logic valid_q, valid_d;
  dir_t dir_q, dir_d;
  logic drop_q, drop_d;
  logic load;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  sync_2ff #(
    .WIDTH(4)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (btn_raw),
    .q_o  (btn_s)
  );

  assign cand  = decode_btn(btn_s);
  assign match = cand.ok && (cand.dir == cand_q);

  // Saturating increments: counters never wrap even if a parameter is out of range.
  assign dcnt_inc = (dcnt_q == DEB_MAX) ? dcnt_q : dcnt_q + DCNT_W'(1);
  assign rcnt_inc = (rcnt_q == R_MAX)   ? rcnt_q : rcnt_q + RCNT_W'(1);
  assign rcnt_tgt = first_q ? R_DELAY : R_PERIOD;
  assign deb_done = (dcnt_inc == DEB_MAX);
  assign rep_due  = (rcnt_inc == rcnt_tgt);

  // ---------------------------------------------------------------------------
  // FSM state register (with its counters)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= DIR_UP;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state; everything holds between ticks
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    cand_d  = cand_q;
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    first_d = first_q;

    if (tick_100ms) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cand.ok) begin
            state_d = ST_CONFIRM;
            cand_d  = cand.dir;
            dcnt_d  = DCNT_W'(1);
          end
        end

        ST_CONFIRM, ST_PRESSED: begin
          if (match) begin
            if (state_q == ST_CONFIRM) begin
              dcnt_d = dcnt_inc;
              if (deb_done) begin
                state_d = ST_PRESSED;
                rcnt_d  = '0;
                first_d = 1'b1;
              end
            end else if (REPEAT_EN) begin
              if (rep_due) begin
                rcnt_d  = '0;
                first_d = 1'b0;
              end else begin
                rcnt_d  = rcnt_inc;
              end
            end
          end else if (cand.ok) begin
            // A different single button restarts the debounce on that direction.
            state_d = ST_CONFIRM;
            cand_d  = cand.dir;
            dcnt_d  = DCNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM output: a move is generated on the tick that confirms or repeats
  // ---------------------------------------------------------------------------
  always_comb begin
    emit = 1'b0;
    if (tick_100ms && match) begin
      if (state_q == ST_CONFIRM)
        emit = deb_done;
      else if (state_q == ST_PRESSED)
        emit = REPEAT_EN && rep_due;
    end
  end

  // ---------------------------------------------------------------------------
  // 1-entry output register. move_drop is registered so it lines up with the
  // move_valid edge the same emit would have produced.
  // ---------------------------------------------------------------------------
  assign load = emit && (!valid_q || move_ready);

  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    drop_d  = emit && !load;
    if (load) begin
      valid_d = 1'b1;
      dir_d   = cand_q;
    end else if (valid_q && move_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dir_q   <= DIR_UP;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dir_q   <= dir_d;
      drop_q  <= drop_d;
    end
  end

  assign move_valid = valid_q;
  assign move_dir   = dir_q;
  assign move_drop  = drop_q;

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Self-checking bench for btn_dir_ctrl: directed table, multi-cycle corner
// sequences and a randomized phase, all checked against a run-length model.
module tb_btn_dir_ctrl;
  import game2048_pkg::*;

  localparam int DEB = 2;
  localparam int REP = 1;
  localparam int DLY = 5;
  localparam int PER = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_100ms = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic move_ready = 1'b1;
  logic move_valid;
  dir_t move_dir;
  logic move_drop;

  always #5 clk = ~clk;

  btn_dir_ctrl #(
    .DEB_TICKS    (DEB),
    .REPEAT_EN    (1'b1),
    .REPEAT_DELAY (DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_100ms(tick_100ms),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .move_ready(move_ready),
    .move_drop (move_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a move fires when a single button has been seen on
  // exactly DEB consecutive ticks, then DLY ticks later, then every PER ticks.
  logic [3:0] h0, h1, m_prev;
  int         m_run;
  logic       m_valid, m_drop;
  dir_t       m_dir;

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] s;
    int         nrun, k;
    logic       emit;
    dir_t       edir;
    if (!rst_n) begin
      h0 <= '0; h1 <= '0; m_prev <= '0; m_run <= 0;
      m_valid <= 1'b0; m_dir <= '0; m_drop <= 1'b0;
    end else begin
      s = h1; emit = 1'b0; edir = '0; nrun = m_run; k = 0;
      if (tick_100ms) begin
        if ($onehot(s)) nrun = (s == m_prev) ? m_run + 1 : 1;
        else            nrun = 0;
        m_prev <= s;
        m_run  <= nrun;
        if (nrun >= DEB) begin
          k = nrun - DEB;
          emit = (k == 0) || (REP != 0 && ((k == DLY) || (k > DLY && (k - DLY) % PER == 0)));
        end
        for (int i = 0; i < 4; i++) if (s[i]) edir = dir_t'(i);
      end
      m_drop <= 1'b0;
      if (emit && (!m_valid || move_ready)) begin
        m_valid <= 1'b1;
        m_dir   <= edir;
      end else if (emit) begin
        m_drop <= 1'b1;
      end else if (m_valid && move_ready) begin
        m_valid <= 1'b0;
      end
      h1 <= h0;
      h0 <= {btn_right, btn_left, btn_down, btn_up};
    end
  end

  always @(negedge clk) begin
    check("model_vs_dut",
          {29'd0, move_valid, move_valid ? move_dir : 2'b00, move_drop},
          {29'd0, m_valid,    m_valid ? m_dir : 2'b00,       m_drop});
  end

  // Event counters sampled away from the active edge.
  int   acc_cnt = 0, valid_cyc = 0, drop_cnt = 0;
  dir_t last_dir = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (move_valid && move_ready) begin
        acc_cnt++;
        last_dir = move_dir;
      end
      if (move_valid) valid_cyc++;
      if (move_drop)  drop_cnt++;
    end
  end

  task automatic set_btn(input logic [3:0] b);
    {btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic do_tick();
    repeat (9) @(negedge clk);
    tick_100ms = 1'b1;
    @(negedge clk);
    tick_100ms = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic snap(output int a, output int v, output int d);
    #1;
    a = acc_cnt; v = valid_cyc; d = drop_cnt;
  endtask

  typedef struct {
    logic [3:0] btn;
    int         hold;
    int         exp_moves;
    dir_t       exp_dir;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int a0, v0, d0, a1, v1, d1;

    vecs[0] = '{4'b0100, 2,  1, DIR_LEFT};
    vecs[1] = '{4'b0001, 9,  3, DIR_UP};
    vecs[2] = '{4'b1001, 6,  0, DIR_UP};
    vecs[3] = '{4'b1000, 1,  0, DIR_UP};
    vecs[4] = '{4'b0010, 7,  2, DIR_DOWN};
    vecs[5] = '{4'b0000, 3,  0, DIR_UP};
    vecs[6] = '{4'b1111, 4,  0, DIR_UP};
    vecs[7] = '{4'b1000, 11, 4, DIR_RIGHT};

    repeat (3) @(negedge clk);
    check("reset_valid", move_valid, 1'b0);
    check("reset_dir",   move_dir,   2'd0);
    check("reset_drop",  move_drop,  1'b0);
    rst_n = 1'b1;
    ticks(2);

    // Directed table, each entry starting from idle.
    for (int i = 0; i < 8; i++) begin
      snap(a0, v0, d0);
      set_btn(vecs[i].btn);
      ticks(vecs[i].hold);
      set_btn(4'b0000);
      ticks(3);
      snap(a1, v1, d1);
      check($sformatf("vec%0d_moves", i), a1 - a0, vecs[i].exp_moves);
      check($sformatf("vec%0d_valid_cycles", i), v1 - v0, vecs[i].exp_moves);
      if (vecs[i].exp_moves > 0) check($sformatf("vec%0d_dir", i), last_dir, vecs[i].exp_dir);
    end

    // Two buttons together, then one released.
    snap(a0, v0, d0);
    set_btn(4'b1001);
    ticks(6);
    snap(a1, v1, d1);
    check("multi_no_move", a1 - a0, 0);
    set_btn(4'b1000);
    do_tick();
    snap(a1, v1, d1);
    check("release_up_1tick", a1 - a0, 0);
    do_tick();
    snap(a1, v1, d1);
    check("release_up_2ticks", a1 - a0, 1);
    check("release_up_dir", last_dir, DIR_RIGHT);
    set_btn(4'b0000);
    ticks(3);

    // Back-pressure: one held move, later repeats dropped.
    move_ready = 1'b0;
    snap(a0, v0, d0);
    set_btn(4'b0010);
    ticks(2);
    #1;
    check("bp_first_valid", move_valid, 1'b1);
    check("bp_first_dir",   move_dir,   DIR_DOWN);
    for (int t = 3; t <= 20; t++) begin
      do_tick();
      #1;
      check($sformatf("bp_hold_t%0d", t), {move_valid, move_dir}, {1'b1, DIR_DOWN});
    end
    snap(a1, v1, d1);
    check("bp_drops", d1 - d0, 7);
    repeat (3) @(negedge clk);
    check("bp_before_ready", move_valid, 1'b1);
    move_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_cleared", move_valid, 1'b0);
    snap(a1, v1, d1);
    check("bp_accepted", a1 - a0, 1);
    set_btn(4'b0000);
    ticks(3);

    // Glitch, then direction switch mid-confirm.
    snap(a0, v0, d0);
    set_btn(4'b1000);
    do_tick();
    set_btn(4'b0000);
    ticks(3);
    snap(a1, v1, d1);
    check("glitch_no_move", a1 - a0, 0);
    set_btn(4'b1000);
    do_tick();
    set_btn(4'b0100);
    do_tick();
    snap(a1, v1, d1);
    check("switch_1tick", a1 - a0, 0);
    do_tick();
    snap(a1, v1, d1);
    check("switch_2ticks", a1 - a0, 1);
    check("switch_dir", last_dir, DIR_LEFT);
    set_btn(4'b0000);
    ticks(3);

    // Reset in the middle of a pending handshake.
    move_ready = 1'b0;
    set_btn(4'b0001);
    ticks(3);
    #1;
    check("prerst_valid", move_valid, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_out", {move_valid, move_dir, move_drop}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    move_ready = 1'b1;
    snap(a0, v0, d0);
    do_tick();
    snap(a1, v1, d1);
    check("postrst_1tick", a1 - a0, 0);
    do_tick();
    snap(a1, v1, d1);
    check("postrst_2ticks", a1 - a0, 1);
    check("postrst_dir", last_dir, DIR_UP);
    set_btn(4'b0000);
    ticks(3);

    // Randomized phase, checked cycle by cycle against the model.
    for (int t = 0; t < 250; t++) begin
      int r, chg_at;
      logic [3:0] nb;
      r = $urandom_range(0, 9);
      chg_at = (r < 5) ? -1 : $urandom_range(0, 9);
      nb = {btn_right, btn_left, btn_down, btn_up};
      if (r >= 5 && r <= 7)  nb = 4'b0001 << $urandom_range(0, 3);
      else if (r == 8)       nb = 4'b0000;
      else if (r == 9)       nb = 4'($urandom_range(0, 15));
      for (int c = 0; c < 10; c++) begin
        if (c == chg_at) set_btn(nb);
        move_ready = ($urandom_range(0, 3) != 0);
        tick_100ms = (c == 9);
        @(negedge clk);
      end
      tick_100ms = 1'b0;
    end
    move_ready = 1'b1;
    set_btn(4'b0000);
    ticks(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
